run_control_dump: RTL and testbench

RUN_CONTROL_DUMP -- requirements
Module: run_control_dump

---
 rtl/run_control_dump.sv | 120 ++++++++++++
 tb/tb_run_control_dump.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_control_dump.sv
// Run controller: holds the CPU in reset, runs it until an end PC or watchdog
// expiry, then streams a window of data memory out over a valid/ready port.
module run_control_dump #(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       MEM_AW         = 8,
  parameter int unsigned       RST_CYCLES     = 3,
  parameter logic [DATA_W-1:0] END_PC         = 'h78,
  parameter int unsigned       DUMP_BASE      = 32,
  parameter int unsigned       DUMP_COUNT     = 96,
  parameter int unsigned       WORDS_PER_LINE = 16,
  parameter int unsigned       TIMEOUT        = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc,
  output logic              cpu_reset,
  output logic              cpu_run,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_eol,
  output logic              dump_last,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {HOLD, RUN, RD, OUT, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  hold_cnt;
  logic [31:0] idx;
  logic [31:0] col;
  logic        hold_done;
  logic        pc_hit;
  logic        to_hit;
  logic        xfer;

  assign hold_done = (hold_cnt == 8'(RST_CYCLES - 1));
  assign pc_hit    = (state == RUN) && (pc == END_PC);
  assign to_hit    = (state == RUN) && (cycle_count == TIMEOUT - 1);
  assign xfer      = (state == OUT) && dump_valid && dump_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= HOLD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      HOLD:    if (hold_done) state_nx = RUN;
      RUN:     if (pc_hit || to_hit) state_nx = (DUMP_COUNT == 0) ? DONE : RD;
      RD:      state_nx = OUT;
      OUT:     if (xfer) state_nx = dump_last ? DONE : RD;
      DONE:    state_nx = DONE;
      default: state_nx = HOLD;
    endcase
  end

  always_comb begin
    cpu_reset = (state == HOLD);
    cpu_run   = (state == RUN);
  end

  // mem_addr is loaded on the edge into RD; the synchronous memory returns the
  // word during the first OUT cycle, which then loads dump_data and raises valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt    <= '0;
      idx         <= '0;
      col         <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
      done        <= 1'b0;
      dump_valid  <= 1'b0;
      dump_eol    <= 1'b0;
      dump_last   <= 1'b0;
      dump_data   <= '0;
      mem_addr    <= '0;
    end else begin
      case (state)
        HOLD: hold_cnt <= hold_cnt + 8'd1;
        RUN: begin
          if (pc_hit || to_hit) begin
            if (!pc_hit) timeout <= 1'b1;
            if (DUMP_COUNT == 0) done <= 1'b1;
            mem_addr <= MEM_AW'(DUMP_BASE + idx);
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + 32'd1;
          end
        end
        OUT: begin
          if (!dump_valid) begin
            dump_data  <= mem_rdata;
            dump_valid <= 1'b1;
            dump_eol   <= (col == WORDS_PER_LINE - 1);
            dump_last  <= (idx == DUMP_COUNT - 1);
          end else if (dump_ready) begin
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_eol   <= 1'b0;
            dump_last  <= 1'b0;
            if (dump_last) begin
              done <= 1'b1;
            end else begin
              idx      <= idx + 32'd1;
              col      <= (col == WORDS_PER_LINE - 1) ? '0 : col + 32'd1;
              mem_addr <= MEM_AW'(DUMP_BASE + idx + 1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_control_dump.sv
// Bench for run_control_dump: three parameterisations, a CPU/PC stimulus model,
// a synchronous random memory and a stream reference computed from the rules.
`timescale 1ns/1ps
module tb_run_control_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst         [3];
  logic [31:0] pc          [3] = '{default: 32'h78};
  logic        cpu_reset   [3];
  logic        cpu_run     [3];
  logic [7:0]  mem_addr    [3];
  logic [31:0] mem_rdata   [3];
  logic        dump_valid  [3];
  logic        dump_ready  [3];
  logic [31:0] dump_data   [3];
  logic        dump_eol    [3];
  logic        dump_last   [3];
  logic        done        [3];
  logic        tmo         [3];
  logic [31:0] cycle_count [3];

  run_control_dump u0 (
    .clk(clk), .reset(rst[0]), .pc(pc[0]), .cpu_reset(cpu_reset[0]), .cpu_run(cpu_run[0]),
    .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]), .dump_valid(dump_valid[0]),
    .dump_ready(dump_ready[0]), .dump_data(dump_data[0]), .dump_eol(dump_eol[0]),
    .dump_last(dump_last[0]), .done(done[0]), .timeout(tmo[0]), .cycle_count(cycle_count[0]));

  run_control_dump #(.TIMEOUT(50), .DUMP_BASE(250), .DUMP_COUNT(10), .WORDS_PER_LINE(4)) u1 (
    .clk(clk), .reset(rst[1]), .pc(pc[1]), .cpu_reset(cpu_reset[1]), .cpu_run(cpu_run[1]),
    .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]), .dump_valid(dump_valid[1]),
    .dump_ready(dump_ready[1]), .dump_data(dump_data[1]), .dump_eol(dump_eol[1]),
    .dump_last(dump_last[1]), .done(done[1]), .timeout(tmo[1]), .cycle_count(cycle_count[1]));

  run_control_dump #(.RST_CYCLES(1), .DUMP_COUNT(0)) u2 (
    .clk(clk), .reset(rst[2]), .pc(pc[2]), .cpu_reset(cpu_reset[2]), .cpu_run(cpu_run[2]),
    .mem_addr(mem_addr[2]), .mem_rdata(mem_rdata[2]), .dump_valid(dump_valid[2]),
    .dump_ready(dump_ready[2]), .dump_data(dump_data[2]), .dump_eol(dump_eol[2]),
    .dump_last(dump_last[2]), .done(done[2]), .timeout(tmo[2]), .cycle_count(cycle_count[2]));

  // Per-instance parameters as seen by the reference model.
  function automatic int p_base(input int i);
    return (i == 1) ? 250 : 32;
  endfunction
  function automatic int p_count(input int i);
    return (i == 1) ? 10 : (i == 2) ? 0 : 96;
  endfunction
  function automatic int p_wpl(input int i);
    return (i == 1) ? 4 : 16;
  endfunction
  function automatic int p_timeout(input int i);
    return (i == 1) ? 50 : 100000;
  endfunction
  function automatic int p_rst(input int i);
    return (i == 2) ? 1 : 3;
  endfunction

  logic [31:0] mem [3][256];

  function automatic logic [31:0] exp_data(input int i, input int k);
    return mem[i][(p_base(i) + k) % 256];
  endfunction
  function automatic bit exp_eol(input int i, input int k);
    return ((k + 1) % p_wpl(i)) == 0;
  endfunction
  function automatic bit exp_last(input int i, input int k);
    return k == p_count(i) - 1;
  endfunction
  // Run cycles counted before the run ends, and whether the watchdog ended it.
  function automatic int exp_cc(input int i, input int target);
    return (target >= 0 && target <= p_timeout(i) - 1) ? target : p_timeout(i) - 1;
  endfunction
  function automatic bit exp_to(input int i, input int target);
    return !(target >= 0 && target <= p_timeout(i) - 1);
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 3; i++) mem_rdata[i] <= mem[i][mem_addr[i]];

  // CPU model: PC equals END_PC whenever the CPU is not running (must be ignored),
  // and during RUN only on run cycle number pc_target.
  int run_seen  [3];
  int pc_target [3] = '{default: -1};
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (rst[i]) run_seen[i] <= 0;
      else if (cpu_run[i]) run_seen[i] <= run_seen[i] + 1;

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      logic [31:0] v;
      if (!cpu_run[i] || run_seen[i] == pc_target[i]) pc[i] = 32'h78;
      else begin
        v = $urandom;
        if (v == 32'h78) v = 32'h0;
        pc[i] = v;
      end
    end

  int checks = 0;
  int errors = 0;

  logic [31:0] q_data [$];
  bit          q_eol  [$];
  bit          q_last [$];
  int c_hold, c_run, c_stab, c_gap_done, c_min_gap, c_valid_seen;
  bit c_expired;

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    dump_ready[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst[i] = 1'b0;
  endtask

  // Resets instance i, runs it and records the stream; stops early when word
  // stop_idx is presented (stop_idx >= 0), on done, or when the bound expires.
  task automatic run_collect(input int i, input int target, input int ready_pct, input int stop_idx);
    int last_run, last_xfer;
    bit stall, se, sl;
    logic [31:0] sd;
    q_data.delete(); q_eol.delete(); q_last.delete();
    c_hold = 0; c_run = 0; c_stab = 0; c_gap_done = -1; c_min_gap = 1000;
    c_valid_seen = 0; c_expired = 1'b0;
    last_run = -1; last_xfer = -1000; stall = 1'b0; sd = '0; se = 1'b0; sl = 1'b0;
    pc_target[i] = target;
    do_reset(i);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (cpu_reset[i]) c_hold++;
      if (cpu_run[i]) begin c_run++; last_run = cyc; end
      if (dump_valid[i]) c_valid_seen++;
      if (stall && (dump_valid[i] !== 1'b1 || dump_data[i] !== sd ||
                    dump_eol[i] !== se || dump_last[i] !== sl)) c_stab++;
      if (done[i]) begin
        c_gap_done = cyc - last_run;
        dump_ready[i] = 1'b0;
        return;
      end
      if (stop_idx >= 0 && dump_valid[i] && q_data.size() == stop_idx) begin
        dump_ready[i] = 1'b0;
        return;
      end
      dump_ready[i] = ($urandom_range(99) < ready_pct);
      stall = dump_valid[i] && !dump_ready[i];
      sd = dump_data[i]; se = dump_eol[i]; sl = dump_last[i];
      if (dump_valid[i] && dump_ready[i]) begin
        q_data.push_back(dump_data[i]);
        q_eol.push_back(dump_eol[i]);
        q_last.push_back(dump_last[i]);
        if (cyc - last_xfer < c_min_gap) c_min_gap = cyc - last_xfer;
        last_xfer = cyc;
      end
      @(negedge clk);
    end
    c_expired = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({cpu_reset[i], cpu_run[i], dump_valid[i], dump_eol[i], dump_last[i], done[i], tmo[i]} !== 7'b1000000) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got %b expected 1000000", i,
                 {cpu_reset[i], cpu_run[i], dump_valid[i], dump_eol[i], dump_last[i], done[i], tmo[i]});
      end
      checks++;
      if (cycle_count[i] !== 32'd0 || dump_data[i] !== 32'd0 || mem_addr[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset_values[%0d]: got cc=%0d data=%h addr=%0d expected all 0", i,
                 cycle_count[i], dump_data[i], mem_addr[i]);
      end
    end
  endtask

  task automatic test_default_dump();
    run_collect(0, 40, 50, -1);
    checks++; if (c_expired) begin errors++; $display("FAIL default_bound: got expired expected done"); end
    checks++; if (c_hold != 3) begin errors++; $display("FAIL default_hold: got %0d expected 3", c_hold); end
    checks++; if (c_run != 41) begin errors++; $display("FAIL default_run_cycles: got %0d expected 41", c_run); end
    checks++; if (cycle_count[0] !== 32'd40) begin errors++; $display("FAIL default_cc: got %0d expected 40", cycle_count[0]); end
    checks++; if (tmo[0] !== 1'b0 || done[0] !== 1'b1 || dump_valid[0] !== 1'b0) begin
      errors++; $display("FAIL default_end: got to=%b done=%b valid=%b expected 0/1/0", tmo[0], done[0], dump_valid[0]);
    end
    checks++; if (c_stab != 0) begin errors++; $display("FAIL default_stall_stable: got %0d changes expected 0", c_stab); end
    checks++; if (q_data.size() != 96) begin errors++; $display("FAIL default_words: got %0d expected 96", q_data.size()); end
    for (int k = 0; k < q_data.size() && k < 96; k++) begin
      checks++;
      if (q_data[k] !== exp_data(0, k) || q_eol[k] !== exp_eol(0, k) || q_last[k] !== exp_last(0, k)) begin
        errors++;
        $display("FAIL default_word[%0d]: got %h/%b/%b expected %h/%b/%b", k, q_data[k], q_eol[k], q_last[k],
                 exp_data(0, k), exp_eol(0, k), exp_last(0, k));
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    run_collect(0, 12, 100, -1);
    bad = 0;
    for (int k = 0; k < q_data.size(); k++) if (q_data[k] !== exp_data(0, k)) bad++;
    checks++; if (c_expired || q_data.size() != 96 || bad != 0) begin
      errors++; $display("FAIL b2b_stream: got %0d words %0d bad expected 96 words 0 bad", q_data.size(), bad);
    end
    checks++; if (c_min_gap < 2) begin errors++; $display("FAIL b2b_throughput: got gap %0d expected >= 2", c_min_gap); end
    checks++; if (cycle_count[0] !== 32'd12) begin errors++; $display("FAIL b2b_cc: got %0d expected 12", cycle_count[0]); end
  endtask

  task automatic scenario_small(input int target, input string tag);
    run_collect(1, target, 40, -1);
    checks++; if (c_expired) begin errors++; $display("FAIL %s_bound: got expired expected done", tag); end
    checks++; if (cycle_count[1] !== 32'(exp_cc(1, target))) begin
      errors++; $display("FAIL %s_cc: got %0d expected %0d", tag, cycle_count[1], exp_cc(1, target));
    end
    checks++; if (tmo[1] !== exp_to(1, target)) begin
      errors++; $display("FAIL %s_timeout: got %b expected %b", tag, tmo[1], exp_to(1, target));
    end
    checks++; if (done[1] !== 1'b1 || c_stab != 0) begin
      errors++; $display("FAIL %s_end: got done=%b unstable=%0d expected 1/0", tag, done[1], c_stab);
    end
    checks++; if (q_data.size() != 10) begin errors++; $display("FAIL %s_words: got %0d expected 10", tag, q_data.size()); end
    for (int k = 0; k < q_data.size() && k < 10; k++) begin
      checks++;
      if (q_data[k] !== exp_data(1, k) || q_eol[k] !== exp_eol(1, k) || q_last[k] !== exp_last(1, k)) begin
        errors++;
        $display("FAIL %s_word[%0d]: got %h/%b/%b expected %h/%b/%b", tag, k, q_data[k], q_eol[k], q_last[k],
                 exp_data(1, k), exp_eol(1, k), exp_last(1, k));
      end
    end
  endtask

  task automatic test_timeout();
    scenario_small(-1, "timeout");
  endtask

  task automatic test_pc_timeout_tie();
    scenario_small(49, "tie");
  endtask

  task automatic test_zero_count();
    run_collect(2, 7, 100, -1);
    checks++; if (c_expired) begin errors++; $display("FAIL zero_bound: got expired expected done"); end
    checks++; if (c_hold != p_rst(2)) begin errors++; $display("FAIL zero_hold: got %0d expected %0d", c_hold, p_rst(2)); end
    checks++; if (c_gap_done != 1) begin errors++; $display("FAIL zero_done_latency: got %0d expected 1", c_gap_done); end
    checks++; if (c_valid_seen != 0) begin errors++; $display("FAIL zero_no_valid: got %0d expected 0", c_valid_seen); end
    checks++; if (cycle_count[2] !== 32'd7 || tmo[2] !== 1'b0) begin
      errors++; $display("FAIL zero_cc: got %0d/%b expected 7/0", cycle_count[2], tmo[2]);
    end
  endtask

  task automatic test_reset_mid_dump();
    int bad;
    run_collect(0, 10, 60, 4);
    checks++; if (dump_valid[0] !== 1'b1 || q_data.size() != 4) begin
      errors++; $display("FAIL mid_precond: got valid=%b words=%0d expected 1/4", dump_valid[0], q_data.size());
    end
    rst[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_reset[0], cpu_run[0], dump_valid[0], dump_eol[0], dump_last[0], done[0], tmo[0]} !== 7'b1000000 ||
        cycle_count[0] !== 32'd0 || dump_data[0] !== 32'd0 || mem_addr[0] !== 8'd0) begin
      errors++;
      $display("FAIL mid_abort: got flags=%b cc=%0d data=%h addr=%0d expected 1000000/0/0/0",
               {cpu_reset[0], cpu_run[0], dump_valid[0], dump_eol[0], dump_last[0], done[0], tmo[0]},
               cycle_count[0], dump_data[0], mem_addr[0]);
    end
    run_collect(0, 25, 50, -1);
    bad = 0;
    for (int k = 0; k < q_data.size(); k++)
      if (q_data[k] !== exp_data(0, k) || q_eol[k] !== exp_eol(0, k) || q_last[k] !== exp_last(0, k)) bad++;
    checks++; if (c_expired || q_data.size() != 96 || bad != 0 || c_stab != 0) begin
      errors++; $display("FAIL mid_rerun_stream: got %0d words %0d bad %0d unstable expected 96/0/0",
                         q_data.size(), bad, c_stab);
    end
    checks++; if (c_hold != 3 || cycle_count[0] !== 32'd25) begin
      errors++; $display("FAIL mid_rerun_run: got hold=%0d cc=%0d expected 3/25", c_hold, cycle_count[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      dump_ready[i] = 1'b0;
      for (int a = 0; a < 256; a++) mem[i][a] = $urandom;
    end
    test_reset();
    test_default_dump();
    test_back_to_back();
    test_timeout();
    test_pc_timeout_tie();
    test_zero_count();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
